rlwe_enc_param: RTL

- Parametrised ring-LWE encryption core for polynomials in Z_P[x]/(x^N+1).
- Computes c0 = b*r0 + r2 + T_SCALE*m and c1 = a*r0 + r1.
- Successor to the fixed-size Enc core: generic P/N, schoolbook negacyclic MAC, explicit busy/done status and output backpressure.
- Sits between the Gaussian sampler, the public-key store and the ciphertext sink.

---
 rtl/rlwe_enc_param.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rlwe_enc_param.sv
// Ring-LWE encryption core over Z_P[x]/(x^N+1): loads r0/r1/r2, message and public key,
// runs a schoolbook negacyclic MAC per output coefficient and streams (c0,c1) with backpressure.
module rlwe_enc_param #(
  parameter int P       = 17,
  parameter int LOGP    = 5,
  parameter int N       = 8,
  parameter int LOGN    = 3,
  parameter int T_SCALE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            gaussian_valid,
  input  logic [LOGP-1:0] gaussian_in,
  input  logic            msg_valid,
  input  logic [N-1:0]    message,
  input  logic            key_valid,
  input  logic [LOGP-1:0] pub_key_a,
  input  logic [LOGP-1:0] pub_key_b,
  input  logic            out_ready,
  output logic            cipher_valid,
  output logic [LOGP-1:0] cipher_c0,
  output logic [LOGP-1:0] cipher_c1,
  output logic            busy,
  output logic            done
);
  localparam int NUM_LANES = 2;
  localparam logic [LOGN+1:0] LAST_S = (LOGN+2)'(3*N-1);
  localparam logic [LOGN+1:0] LAST_N = (LOGN+2)'(N-1);
  localparam logic [LOGN+1:0] CNT1   = (LOGN+2)'(1);
  localparam logic [LOGN-1:0] K_LAST = LOGN'(N-1);
  localparam logic [LOGN-1:0] K1     = LOGN'(1);
  localparam logic [LOGN:0]   J1     = (LOGN+1)'(1);
  localparam logic [LOGP:0]   P1     = (LOGP+1)'(P);
  localparam logic [LOGP+1:0] P2     = (LOGP+2)'(P);
  localparam logic [LOGP+1:0] T2     = (LOGP+2)'(T_SCALE);

  typedef enum logic [2:0] {IDLE, LOAD_R, LOAD_M, LOAD_K, MAC, OUT} state_t;
  state_t state;

  logic [LOGN+1:0] cnt;
  logic [LOGN-1:0] k;
  logic [LOGN:0]   j;
  logic [NUM_LANES-1:0][LOGP-1:0] acc, lane_coef, lane_nxt;

  logic [LOGP-1:0] r0_mem [N];
  logic [LOGP-1:0] r1_mem [N];
  logic [LOGP-1:0] r2_mem [N];
  logic [LOGP-1:0] a_mem  [N];
  logic [LOGP-1:0] b_mem  [N];
  logic [LOGP-1:0] c0_mem [N];
  logic [LOGP-1:0] c1_mem [N];
  logic [N-1:0]    msg;

  logic [LOGN-1:0] jj, idx, ix, o_nxt;
  logic            fin, neg;
  logic [LOGP-1:0] r_sel, c0_fin, c1_fin;
  logic [LOGP:0]   c1_sum;
  logic [LOGP+1:0] c0_sum;

  // j == N marks the finalize slot that closes each output coefficient
  always_comb begin
    jj           = j[LOGN-1:0];
    fin          = j[LOGN];
    idx          = k - jj;
    neg          = jj > k;
    ix           = cnt[LOGN-1:0];
    o_nxt        = ix + K1;
    r_sel        = r0_mem[idx];
    lane_coef[0] = a_mem[jj];
    lane_coef[1] = b_mem[jj];
    c1_sum       = {1'b0, acc[0]} + {1'b0, r1_mem[k]};
    c1_fin       = (c1_sum >= P1) ? LOGP'(c1_sum - P1) : LOGP'(c1_sum);
    c0_sum       = {2'b0, acc[1]} + {2'b0, r2_mem[k]} + (msg[k] ? T2 : '0);
    c0_fin       = LOGP'(c0_sum % P2);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      rlwe_mac_lane #(.P(P), .LOGP(LOGP)) u_lane (
        .acc  (acc[g]),
        .coef (lane_coef[g]),
        .r    (r_sel),
        .neg  (neg),
        .nxt  (lane_nxt[g])
      );
    end
  endgenerate

  // Coefficient storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (state == LOAD_R && gaussian_valid) begin
      case (cnt[LOGN+1:LOGN])
        2'd0:    r0_mem[ix] <= gaussian_in;
        2'd1:    r1_mem[ix] <= gaussian_in;
        default: r2_mem[ix] <= gaussian_in;
      endcase
    end
    if (state == LOAD_M && msg_valid) msg <= message;
    if (state == LOAD_K && key_valid) begin
      a_mem[ix] <= pub_key_a;
      b_mem[ix] <= pub_key_b;
    end
    if (state == MAC && fin) begin
      c0_mem[k] <= c0_fin;
      c1_mem[k] <= c1_fin;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      k            <= '0;
      j            <= '0;
      acc          <= '0;
      cipher_valid <= 1'b0;
      cipher_c0    <= '0;
      cipher_c1    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          state <= LOAD_R;
          busy  <= 1'b1;
          cnt   <= '0;
        end
        LOAD_R: if (gaussian_valid) begin
          if (cnt == LAST_S) begin
            cnt   <= '0;
            state <= LOAD_M;
          end else cnt <= cnt + CNT1;
        end
        LOAD_M: if (msg_valid) state <= LOAD_K;
        LOAD_K: if (key_valid) begin
          if (cnt == LAST_N) begin
            cnt   <= '0;
            k     <= '0;
            j     <= '0;
            acc   <= '0;
            state <= MAC;
          end else cnt <= cnt + CNT1;
        end
        MAC: if (fin) begin
          acc <= '0;
          j   <= '0;
          k   <= k + K1;
          if (k == K_LAST) begin
            state        <= OUT;
            cipher_valid <= 1'b1;
            cipher_c0    <= c0_mem[0];
            cipher_c1    <= c1_mem[0];
          end
        end else begin
          acc <= lane_nxt;
          j   <= j + J1;
        end
        OUT: if (out_ready) begin
          if (cnt == LAST_N) begin
            cnt          <= '0;
            cipher_valid <= 1'b0;
            cipher_c0    <= '0;
            cipher_c1    <= '0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt       <= cnt + CNT1;
            cipher_c0 <= c0_mem[o_nxt];
            cipher_c1 <= c1_mem[o_nxt];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// One modular multiply-accumulate step: nxt = (acc +/- coef*r) mod P, all values in [0,P-1].
module rlwe_mac_lane #(
  parameter int P    = 17,
  parameter int LOGP = 5
) (
  input  logic [LOGP-1:0] acc,
  input  logic [LOGP-1:0] coef,
  input  logic [LOGP-1:0] r,
  input  logic            neg,
  output logic [LOGP-1:0] nxt
);
  localparam logic [2*LOGP-1:0] PM = (2*LOGP)'(P);
  localparam logic [LOGP:0]     PS = (LOGP+1)'(P);

  logic [2*LOGP-1:0] prod;
  logic [LOGP-1:0]   pm;
  logic [LOGP:0]     sum, dif;

  always_comb begin
    prod = {{LOGP{1'b0}}, coef} * {{LOGP{1'b0}}, r};
    pm   = LOGP'(prod % PM);
    sum  = {1'b0, acc} + {1'b0, pm};
    dif  = {1'b0, acc} - {1'b0, pm};
    if (neg) nxt = (acc < pm) ? LOGP'(dif + PS) : LOGP'(dif);
    else     nxt = (sum >= PS) ? LOGP'(sum - PS) : LOGP'(sum);
  end
endmodule
